// File: rtl/branch_resolver_pkg.sv
// Shared field layout, branch-type encodings and FSM states for the EX-stage branch resolver.
package branch_resolver_pkg;

    localparam int SIZE_OF_BRANCH_INFO = 67;
    localparam int BRANCH_INFO_PC_HI   = 66;
    localparam int BRANCH_INFO_PC_LO   = 35;
    localparam int BRANCH_INFO_TAKEN   = 34;
    localparam int BRANCH_INFO_TAR_HI  = 33;
    localparam int BRANCH_INFO_TAR_LO  = 2;

    localparam int PACK_DIR    = 87;
    localparam int PACK_TAR_HI = 86;
    localparam int PACK_TAR_LO = 55;

    localparam logic [1:0] BTYPE_COND = 2'd0;
    localparam logic [1:0] BTYPE_JUMP = 2'd1;
    localparam logic [1:0] BTYPE_CALL = 2'd2;
    localparam logic [1:0] BTYPE_RET  = 2'd3;

    typedef enum logic [1:0] {
        BR_IDLE    = 2'd0,
        BR_WAIT_DS = 2'd1,
        BR_FLUSH   = 2'd2
    } br_state_t;

    function automatic logic [SIZE_OF_BRANCH_INFO-1:0] pack_branch_info(
        input logic [31:0] pc,
        input logic        taken,
        input logic [31:0] target,
        input logic [1:0]  btype
    );
        return {pc, taken, target, btype};
    endfunction

endpackage

// File: rtl/branch_resolver_cmp.sv
// Combinational misprediction detect and correct-PC generation for a resolved branch.
module branch_cmp (
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        pdir,
    input  logic [31:0] ptar,
    output logic        mispred,
    output logic [31:0] correct_pc
);

    // A taken branch that was predicted taken can still miss on its target.
    assign mispred    = (ex_taken != pdir) | (ex_taken & pdir & (ex_target != ptar));
    // Not-taken resumes after the delay slot.
    assign correct_pc = ex_taken ? ex_target : (ex_pc + 32'd8);

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolution: predictor update packet, delay-slot-aware flush/redirect, perf counters.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int INFO_W = SIZE_OF_BRANCH_INFO,
    parameter int PACK_W = 88
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              ex_kill,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [1:0]        ex_btype,
    input  logic [31:0]       ex_pc,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    input  logic [PACK_W-1:0] corr_pack_i,
    input  logic              ds_valid,
    output logic [INFO_W-1:0] branch_info_o,
    output logic              flush_o,
    output logic [31:0]       redirect_pc_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    br_state_t   state;
    br_state_t   state_next;
    logic        resolve;
    logic        mispred;
    logic [31:0] correct_pc;
    logic        pdir;
    logic [31:0] ptar;
    logic        unused_pack_bits;

    assign pdir             = corr_pack_i[PACK_DIR];
    assign ptar             = corr_pack_i[PACK_TAR_HI:PACK_TAR_LO];
    assign unused_pack_bits = ^corr_pack_i[PACK_TAR_LO-1:0];

    branch_cmp u_cmp (
        .ex_pc      (ex_pc),
        .ex_taken   (ex_taken),
        .ex_target  (ex_target),
        .pdir       (pdir),
        .ptar       (ptar),
        .mispred    (mispred),
        .correct_pc (correct_pc)
    );

    assign resolve = ex_valid & ex_is_branch & ~stall & ~ex_kill & (state == BR_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            BR_IDLE: begin
                if (resolve & mispred)
                    state_next = ds_valid ? BR_FLUSH : BR_WAIT_DS;
            end
            BR_WAIT_DS: begin
                if (ds_valid & ~stall)
                    state_next = BR_FLUSH;
            end
            BR_FLUSH: begin
                if (~stall)
                    state_next = BR_IDLE;
            end
            default: state_next = BR_IDLE;
        endcase
        // A CP0 flush overrides everything, stall included.
        if (ex_kill)
            state_next = BR_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= BR_IDLE;
            flush_o       <= 1'b0;
            redirect_pc_o <= 32'd0;
            branch_info_o <= '0;
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
        end else begin
            state         <= state_next;
            flush_o       <= (state_next == BR_FLUSH);
            branch_info_o <= resolve ? INFO_W'(pack_branch_info(ex_pc, ex_taken, ex_target, ex_btype))
                                     : '0;
            if (resolve) begin
                branch_cnt_o <= branch_cnt_o + CNT_W'(1);
                if (mispred) begin
                    mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
                    redirect_pc_o <= correct_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed plus randomized bench for branch_resolver against a behavioural reference model.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        ex_kill = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic [1:0]  ex_btype = 2'd0;
    logic [31:0] ex_pc = 32'd0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'd0;
    logic [87:0] corr_pack = 88'd0;
    logic        ds_valid = 1'b0;

    logic [66:0] info;
    logic        flush;
    logic [31:0] redirect;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
    logic [66:0] info4;
    logic        flush4;
    logic [31:0] redirect4;
    logic [3:0]  bcnt4;
    logic [3:0]  mcnt4;

    branch_resolver dut (
        .clk(clk), .rst(rst), .stall(stall), .ex_kill(ex_kill), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_btype(ex_btype), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .corr_pack_i(corr_pack), .ds_valid(ds_valid),
        .branch_info_o(info), .flush_o(flush), .redirect_pc_o(redirect),
        .branch_cnt_o(bcnt), .mispred_cnt_o(mcnt)
    );

    branch_resolver #(.CNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .stall(stall), .ex_kill(ex_kill), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_btype(ex_btype), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .corr_pack_i(corr_pack), .ds_valid(ds_valid),
        .branch_info_o(info4), .flush_o(flush4), .redirect_pc_o(redirect4),
        .branch_cnt_o(bcnt4), .mispred_cnt_o(mcnt4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a pending redirect is either waiting for its delay slot or being flushed.
    logic [66:0] m_info;
    logic        m_flush;
    logic [31:0] m_redirect;
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;
    bit          m_await_ds;
    bit          m_flushing;

    task automatic model_reset();
        m_info = '0; m_flush = 1'b0; m_redirect = '0; m_bcnt = '0; m_mcnt = '0;
        m_await_ds = 1'b0; m_flushing = 1'b0;
    endtask

    task automatic model_edge();
        bit          busy;
        bit          r;
        bit          miss;
        logic [31:0] fix;
        logic [31:0] ptar;
        busy = m_await_ds || m_flushing;
        r    = ex_valid && ex_is_branch && !stall && !ex_kill && !busy;
        ptar = corr_pack[86:55];
        miss = (ex_taken != corr_pack[87]) || (ex_taken && ex_target != ptar);
        fix  = ex_taken ? ex_target : ex_pc + 32'd8;
        m_info = r ? {ex_pc, ex_taken, ex_target, ex_btype} : 67'd0;
        if (r) begin
            m_bcnt = m_bcnt + 1;
            if (miss) begin
                m_mcnt = m_mcnt + 1;
                m_redirect = fix;
                m_flushing = ds_valid;
                m_await_ds = !ds_valid;
            end
        end else if (ex_kill) begin
            m_await_ds = 1'b0;
            m_flushing = 1'b0;
        end else if (m_await_ds) begin
            if (ds_valid && !stall) begin
                m_await_ds = 1'b0;
                m_flushing = 1'b1;
            end
        end else if (m_flushing && !stall) begin
            m_flushing = 1'b0;
        end
        m_flush = m_flushing;
    endtask

    task automatic compare_all();
        chk("info", info, m_info);
        chk("flush", flush, m_flush);
        if (m_flush) chk("redirect", redirect, m_redirect);
        chk("bcnt", bcnt, m_bcnt);
        chk("mcnt", mcnt, m_mcnt);
        chk("bcnt_w4", bcnt4, m_bcnt[3:0]);
        chk("mcnt_w4", mcnt4, m_mcnt[3:0]);
        chk("flush_w4", flush4, m_flush);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_kill = 1'b0; stall = 1'b0; ds_valid = 1'b0;
    endtask

    task automatic set_br(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                          input logic [1:0] bt, input logic pdir, input logic [31:0] ptar,
                          input logic ds);
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = pc; ex_taken = taken; ex_target = tgt;
        ex_btype = bt; corr_pack = {pdir, ptar, 23'd0, 32'($urandom)}; ds_valid = ds;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst_info", info, 67'd0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_redirect", redirect, 32'd0);
        chk("rst_bcnt", bcnt, 32'd0);
        chk("rst_mcnt", mcnt, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();

        // Correctly predicted taken branch
        set_br(32'h8000_0100, 1'b1, 32'h8000_0200, 2'd1, 1'b1, 32'h8000_0200, 1'b0);
        step();
        chk("t1_info", info, {32'h8000_0100, 1'b1, 32'h8000_0200, 2'd1});
        chk("t1_bcnt", bcnt, 32'd1);
        idle_in();
        step();
        chk("t1_info_drop", info, 67'd0);
        step();
        chk("t1_no_flush", flush, 1'b0);

        // Direction miss with delay slot already in
        set_br(32'h0000_1000, 1'b0, 32'h0000_1234, 2'd0, 1'b1, 32'h0000_1234, 1'b1);
        step();
        chk("t2_flush", flush, 1'b1);
        chk("t2_redir", redirect, 32'h0000_1008);
        chk("t2_mcnt", mcnt, 32'd1);
        idle_in();
        step();
        chk("t2_flush_drop", flush, 1'b0);

        // Target miss, delay slot arrives late
        set_br(32'h0000_1800, 1'b1, 32'h0000_2000, 2'd0, 1'b1, 32'h0000_3000, 1'b0);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_wait", flush, 1'b0);
        end
        ds_valid = 1'b1;
        step();
        chk("t3_flush", flush, 1'b1);
        chk("t3_redir", redirect, 32'h0000_2000);
        ds_valid = 1'b0;
        step();

        // Stall blocks resolution, then releases it
        set_br(32'h0000_4000, 1'b0, 32'h0000_5000, 2'd2, 1'b0, 32'h0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_nopkt", info, 67'd0);
        end
        stall = 1'b0;
        step();
        chk("t4_pkt", info, {32'h0000_4000, 1'b0, 32'h0000_5000, 2'd2});
        idle_in();
        step();

        // Stall during flush holds flush_o
        set_br(32'h0000_6000, 1'b1, 32'h0000_7000, 2'd3, 1'b0, 32'h0, 1'b1);
        step();
        idle_in();
        stall = 1'b1;
        step();
        step();
        chk("t4_flush_hold", flush, 1'b1);
        chk("t4_redir_hold", redirect, 32'h0000_7000);
        stall = 1'b0;
        step();
        chk("t4_flush_rel", flush, 1'b0);

        // Kill while waiting for delay slot
        set_br(32'h0000_8000, 1'b1, 32'h0000_9000, 2'd0, 1'b0, 32'h0, 1'b0);
        step();
        idle_in();
        ex_kill = 1'b1;
        step();
        chk("t5_kill_flush", flush, 1'b0);
        ex_kill = 1'b0;
        ds_valid = 1'b1;
        step();
        step();
        chk("t5_no_flush", flush, 1'b0);
        set_br(32'h0000_a000, 1'b1, 32'h0000_b000, 2'd0, 1'b0, 32'h0, 1'b1);
        ex_kill = 1'b1;
        step();
        chk("t5_kill_info", info, 67'd0);
        idle_in();
        step();

        // Async reset in the middle of WAIT_DS
        set_br(32'h0000_c000, 1'b0, 32'h0000_d000, 2'd0, 1'b1, 32'h0, 1'b0);
        step();
        idle_in();
        rst = 1'b1;
        #1;
        chk("t6_info", info, 67'd0);
        chk("t6_flush", flush, 1'b0);
        chk("t6_redirect", redirect, 32'd0);
        chk("t6_bcnt", bcnt, 32'd0);
        chk("t6_mcnt", mcnt, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();

        // Sixteen correctly predicted branches wrap the narrow counter
        for (int i = 0; i < 16; i++) begin
            logic        tk;
            logic [31:0] tg;
            tk = 1'($urandom);
            tg = $urandom;
            set_br(32'h0001_0000 + 32'(i * 4), tk, tg, 2'd0, tk, tg, 1'b0);
            step();
        end
        idle_in();
        step();
        chk("t7_wrap4", bcnt4, 4'd0);
        chk("t7_cnt16", bcnt, 32'd16);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tg;
            tg = $urandom;
            ex_valid     = ($urandom % 4) != 0;
            ex_is_branch = ($urandom % 3) != 0;
            ex_taken     = 1'($urandom);
            ex_pc        = ($urandom % 8 == 0) ? 32'hffff_fffc : $urandom;
            ex_target    = tg;
            ex_btype     = 2'($urandom);
            corr_pack    = {1'($urandom), (($urandom % 2) != 0) ? tg : 32'($urandom), 23'd0, 32'($urandom)};
            ds_valid     = 1'($urandom);
            stall        = ($urandom % 4) == 0;
            ex_kill      = ($urandom % 16) == 0;
            step();
        end
        idle_in();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- EX-stage unit that closes the branch prediction loop.
- Compares each resolved branch against the prediction carried in its correction pack, and registers the predictor update packet (branch_info) back to the front-end predictor.
- Sequences the pipeline flush/redirect on a misprediction, honouring the MIPS delay slot.
- Keeps branch and misprediction counters for performance monitoring.

Parameters:
- CNT_W, 32, width of the branch and mispredict counters (wrap-around).
- INFO_W, 67, branch_info width: {pc[31:0], taken, target[31:0], btype[1:0]}.
- PACK_W, 88, correction pack width; bit 87 = predicted dir, bits 86:55 = predicted target.

Ports:
- clk  in  1  clock; all state rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  EX stall; freezes all state and blocks new resolutions.
- ex_kill  in  1  exception/eret flush from CP0; aborts any pending redirect.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_branch  in  1  EX instruction is a branch/jump.
- ex_btype  in  2  branch type (BTYPE encoding from defines).
- ex_pc  in  32  PC of the EX instruction.
- ex_taken  in  1  actual direction.
- ex_target  in  32  actual target.
- corr_pack_i  in  PACK_W  prediction pack travelling with the instruction.
- ds_valid  in  1  delay-slot instruction has entered ID/EX (is safe from flush).
- branch_info_o  out  INFO_W  predictor update; all-zero means no update.
- flush_o  out  1  one-cycle flush of IF/ID younger than the delay slot.
- redirect_pc_o  out  32  fetch redirect target, valid when flush_o=1.
- branch_cnt_o  out  CNT_W  resolved branches.
- mispred_cnt_o  out  CNT_W  mispredicted branches.

Behaviour:
- Reset (async, rst=1): branch_info_o=0, flush_o=0, redirect_pc_o=0, counters=0, state=IDLE.
- Resolve event R = ex_valid & ex_is_branch & ~stall & ~ex_kill & state==IDLE.
- Prediction fields: pdir = corr_pack_i[87], ptar = corr_pack_i[86:55].
- Mispredict M = (ex_taken != pdir) | (ex_taken & pdir & ex_target != ptar).
- Correct PC C = ex_taken ? ex_target : ex_pc + 8, computed mod 2^32.
- Update packet:
  - On R: branch_info_o <= {ex_pc, ex_taken, ex_target, ex_btype} on the next edge, held exactly one cycle, then zero.
  - Emitted for every resolved branch, including correctly predicted ones.
  - If ex_taken=0, the target field is ex_target unmodified.
- Counters: branch_cnt increments on R. mispred_cnt increments on R&M. Both wrap at 2^CNT_W.
- FSM states: IDLE, WAIT_DS, FLUSH.
  - IDLE: on R&M, latch C into redirect_pc_o. Go to FLUSH if ds_valid=1 in the same cycle, else WAIT_DS.
  - WAIT_DS: stay until ds_valid=1 & ~stall, then FLUSH.
  - FLUSH: flush_o=1 for exactly one cycle, then IDLE. Under stall, flush_o stays asserted and the state is held until stall=0.
- ex_kill (any state, not stall-gated): next state IDLE, flush_o=0, no packet for the EX instruction, counters unchanged. Already-latched redirect_pc_o is don't-care.
- While state != IDLE, further branches are not resolved (R=0). The pipeline guarantees the delay slot is not a branch.
- flush_o is registered; redirect_pc_o is stable whenever flush_o=1.
- stall=1 in IDLE: no packet, no count, no state change; branch_info_o still drops to 0 after its one pulse.

Decomposition:
- Shared defines (existing defines file):
  - SIZE_OF_BRANCH_INFO, BRANCH_INFO_PC field ranges.
  - Correction-pack field ranges (PACK_DIR=87, PACK_TAR=86:55).
  - BTYPE_* encodings.
  - FSM state encodings (BR_IDLE, BR_WAIT_DS, BR_FLUSH).
- Sub-module branch_cmp: combinational M and C generation. The FSM, packet register and counters stay in the top.

Test Plan:
- Correct taken: ex_pc=0x8000_0100, ex_taken=1, ex_target=0x8000_0200, pack dir=1, tar=0x8000_0200 -> next cycle branch_info_o={0x80000100,1,0x80000200,btype} for 1 cycle; flush_o never 1; branch_cnt=1, mispred_cnt=0.
- Direction miss, ds_valid=1: pc=0x1000, taken=0, pack dir=1 -> redirect_pc_o=0x1008, flush_o=1 exactly one cycle later; mispred_cnt=1.
- Target miss, ds_valid late: taken=1, target=0x2000, pack tar=0x3000, ds_valid low 3 cycles -> stays in WAIT_DS, flush_o asserts the cycle after ds_valid rises with redirect 0x2000.
- Stall interplay: branch presented with stall=1 for 2 cycles -> no packet/count; packet one cycle after stall drops. Stall during FLUSH -> flush_o held until stall=0.
- Kill: mispredict then ex_kill in WAIT_DS -> IDLE, flush_o never asserted. Branch with ex_kill=1 -> branch_info_o stays 0, counters unchanged.
- Reset/wrap: assert rst mid-WAIT_DS -> all outputs 0 immediately (async). CNT_W=4 with 16 branches -> branch_cnt wraps to 0.
